// File: rtl/uart_axi_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_axi_sequencer_pkg
// Description : Shared register offsets, STAT bit positions, AXI response
//               codes and FSM state encoding for the UART Lite sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_axi_sequencer_pkg;

  // UART Lite register offsets relative to the base address
  localparam logic [31:0] c_UART_RX_OFS   = 32'h0000_0000;
  localparam logic [31:0] c_UART_TX_OFS   = 32'h0000_0004;
  localparam logic [31:0] c_UART_STAT_OFS = 32'h0000_0008;

  // STAT register bit positions
  localparam int c_STAT_RX_VALID_BIT = 0;
  localparam int c_STAT_TX_FULL_BIT  = 3;

  // AXI response code for a successful transfer
  localparam logic [1:0] c_AXI_RESP_OKAY = 2'b00;

  // Sequencer states: one AXI transaction in flight at any time
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_S_AR  = 3'd1,
    ST_S_R   = 3'd2,
    ST_RX_AR = 3'd3,
    ST_RX_R  = 3'd4,
    ST_TX_AW = 3'd5,
    ST_TX_B  = 3'd6
  } state_t;

  // Any response other than OKAY is reported as an error
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != c_AXI_RESP_OKAY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_axi_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered storage. The head entry is
//               presented combinationally from the array, so dout is valid in
//               the same cycle empty deasserts. Push and pop together are
//               honoured even when full.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);

  localparam int              c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL_CNT = (c_AW+1)'(DEPTH);

  logic [W-1:0]    r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_FULL_CNT);
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr];

  // Storage array: no reset needed, contents are qualified by the count
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_axi_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : uart_axi_sequencer
// Description : Bridges the core byte-I/O handshake to an AXI4-Lite UART Lite.
//               Polls STAT, then issues either an RX register read or a TX
//               register write, alternating when both directions are ready.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_axi_sequencer
  import uart_axi_sequencer_pkg::*;
#(
  parameter logic [31:0] UART_BASE = 32'h0000_0000,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  // core output direction
  input  logic        i_out_req,
  input  logic [31:0] i_out_data,
  output logic        o_out_busy,
  // core input direction
  input  logic        i_in_req,
  output logic [7:0]  o_in_data,
  output logic        o_in_valid,
  output logic        o_axi_err,
  // AXI4-Lite write address
  output logic [31:0] o_axi_awaddr,
  output logic [2:0]  o_axi_awprot,
  output logic        o_axi_awvalid,
  input  logic        i_axi_awready,
  // AXI4-Lite write data
  output logic [31:0] o_axi_wdata,
  output logic [3:0]  o_axi_wstrb,
  output logic        o_axi_wvalid,
  input  logic        i_axi_wready,
  // AXI4-Lite write response
  input  logic [1:0]  i_axi_bresp,
  input  logic        i_axi_bvalid,
  output logic        o_axi_bready,
  // AXI4-Lite read address
  output logic [31:0] o_axi_araddr,
  output logic [2:0]  o_axi_arprot,
  output logic        o_axi_arvalid,
  input  logic        i_axi_arready,
  // AXI4-Lite read data
  input  logic [31:0] i_axi_rdata,
  input  logic [1:0]  i_axi_rresp,
  input  logic        i_axi_rvalid,
  output logic        o_axi_rready
);

  state_t      r_state;
  logic        r_prio_rx;
  logic        r_stat_rx;
  logic        r_stat_txfull;
  logic        r_axi_err;
  logic        r_arvalid;
  logic [31:0] r_araddr;
  logic        r_rready;
  logic        r_awvalid;
  logic        r_wvalid;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic        r_bready;

  logic       w_tx_empty;
  logic       w_tx_full;
  logic [7:0] w_tx_head;
  logic       w_rx_empty;
  logic       w_rx_full;
  logic       w_r_hs;
  logic       w_b_hs;
  logic       w_rx_ok;
  logic       w_tx_ok;
  logic       w_go_rx;
  logic       w_go_tx;
  logic       w_aw_done;
  logic       w_w_done;
  logic       w_tx_accept;
  logic       w_rx_push;
  logic       w_resp_err;
  logic       w_unused_bits;

  // Handshakes; rready/bready are only ever high in their own states
  assign w_r_hs = r_rready & i_axi_rvalid;
  assign w_b_hs = r_bready & i_axi_bvalid;

  // Direction decision is made from the live STAT data at the R handshake
  assign w_rx_ok = i_axi_rdata[c_STAT_RX_VALID_BIT] & ~w_rx_full;
  assign w_tx_ok = ~i_axi_rdata[c_STAT_TX_FULL_BIT] & ~w_tx_empty;
  assign w_go_rx = w_rx_ok & (~w_tx_ok | r_prio_rx);
  assign w_go_tx = w_tx_ok & (~w_rx_ok | ~r_prio_rx);

  // AW and W may complete in different cycles; the write is done once both have
  assign w_aw_done   = ~r_awvalid | i_axi_awready;
  assign w_w_done    = ~r_wvalid | i_axi_wready;
  assign w_tx_accept = (r_state == ST_TX_AW) & w_aw_done & w_w_done;
  assign w_rx_push   = (r_state == ST_RX_R) & w_r_hs;

  assign w_resp_err = (w_r_hs & resp_is_err(i_axi_rresp)) |
                      (w_b_hs & resp_is_err(i_axi_bresp));

  // Upper data bits are don't-care; STAT copies are kept for observability
  assign w_unused_bits = ^{i_out_data[31:8], i_axi_rdata[31:8], r_stat_rx, r_stat_txfull};

  sync_fifo #(
    .W     (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_out_req),
    .i_pop   (w_tx_accept),
    .i_din   (i_out_data[7:0]),
    .o_dout  (w_tx_head),
    .o_empty (w_tx_empty),
    .o_full  (w_tx_full)
  );

  sync_fifo #(
    .W     (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_pop   (i_in_req),
    .i_din   (i_axi_rdata[7:0]),
    .o_dout  (o_in_data),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full)
  );

  // Sequencer FSM with registered AXI outputs; reset drops every valid at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_prio_rx     <= 1'b0;
      r_stat_rx     <= 1'b0;
      r_stat_txfull <= 1'b0;
      r_axi_err     <= 1'b0;
      r_arvalid     <= 1'b0;
      r_araddr      <= '0;
      r_rready      <= 1'b0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_awaddr      <= '0;
      r_wdata       <= '0;
      r_bready      <= 1'b0;
    end else begin
      if (w_resp_err) begin
        r_axi_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (!w_tx_empty || !w_rx_full) begin
            r_arvalid <= 1'b1;
            r_araddr  <= UART_BASE + c_UART_STAT_OFS;
            r_state   <= ST_S_AR;
          end
        end
        ST_S_AR: begin
          if (i_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_S_R;
          end
        end
        ST_S_R: begin
          if (i_axi_rvalid) begin
            r_rready      <= 1'b0;
            r_stat_rx     <= i_axi_rdata[c_STAT_RX_VALID_BIT];
            r_stat_txfull <= i_axi_rdata[c_STAT_TX_FULL_BIT];
            if (w_rx_ok && w_tx_ok) begin
              r_prio_rx <= ~r_prio_rx;
            end
            if (w_go_rx) begin
              r_arvalid <= 1'b1;
              r_araddr  <= UART_BASE + c_UART_RX_OFS;
              r_state   <= ST_RX_AR;
            end else if (w_go_tx) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awaddr  <= UART_BASE + c_UART_TX_OFS;
              r_wdata   <= {24'b0, w_tx_head};
              r_state   <= ST_TX_AW;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_RX_AR: begin
          if (i_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RX_R;
          end
        end
        ST_RX_R: begin
          if (i_axi_rvalid) begin
            r_rready <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_TX_AW: begin
          if (r_awvalid && i_axi_awready) begin
            r_awvalid <= 1'b0;
          end
          if (r_wvalid && i_axi_wready) begin
            r_wvalid <= 1'b0;
          end
          if (w_tx_accept) begin
            r_bready <= 1'b1;
            r_state  <= ST_TX_B;
          end
        end
        ST_TX_B: begin
          if (i_axi_bvalid) begin
            r_bready <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_out_busy    = w_tx_full;
  assign o_in_valid    = ~w_rx_empty;
  assign o_axi_err     = r_axi_err;
  assign o_axi_awaddr  = r_awaddr;
  assign o_axi_awprot  = 3'b000;
  assign o_axi_awvalid = r_awvalid;
  assign o_axi_wdata   = r_wdata;
  assign o_axi_wstrb   = 4'b0001;
  assign o_axi_wvalid  = r_wvalid;
  assign o_axi_bready  = r_bready;
  assign o_axi_araddr  = r_araddr;
  assign o_axi_arprot  = 3'b000;
  assign o_axi_arvalid = r_arvalid;
  assign o_axi_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_uart_axi_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_axi_sequencer
// Description : Directed self-checking bench for uart_axi_sequencer with a
//               zero-wait AXI4-Lite UART Lite slave model and transaction log.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_axi_sequencer;

  localparam logic [31:0] c_BASE = 32'h4000_0000;
  localparam logic [7:0]  c_K_S  = 8'h53;  // STAT read
  localparam logic [7:0]  c_K_R  = 8'h52;  // RX read
  localparam logic [7:0]  c_K_W  = 8'h57;  // TX write

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r_out_req;
  logic [31:0] r_out_data;
  logic        w_out_busy;
  logic        r_in_req;
  logic [7:0]  w_in_data;
  logic        w_in_valid;
  logic        w_axi_err;
  logic [31:0] w_awaddr;
  logic [2:0]  w_awprot;
  logic        w_awvalid;
  logic        w_awready;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic        w_wvalid;
  logic        w_wready;
  logic [1:0]  r_bresp;
  logic        r_bvalid;
  logic        w_bready;
  logic [31:0] w_araddr;
  logic [2:0]  w_arprot;
  logic        w_arvalid;
  logic        w_arready;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_rvalid;
  logic        w_rready;

  // slave model controls
  logic [31:0] r_stat_val;
  logic [1:0]  r_stat_resp;
  logic [31:0] r_rx_val;
  logic        r_aw_en;
  logic        r_aw_got;
  logic        r_w_got;
  logic [31:0] r_aw_addr_q;
  logic [31:0] r_w_data_q;
  logic        w_aw_hit;
  logic        w_w_hit;

  // transaction log
  logic [7:0]  log_kind[$];
  logic [31:0] wr_data[$];
  logic [31:0] wr_addr[$];
  logic [31:0] rx_addr[$];

  int n_cmp = 0;
  int n_err = 0;
  int wstart;
  int lstart;
  int nw;
  int nr;
  logic [7:0] prev_kind;
  logic       alt_ok;
  logic       pre_ok;

  always #5 clk = ~clk;

  uart_axi_sequencer #(
    .UART_BASE (c_BASE),
    .TX_DEPTH  (16),
    .RX_DEPTH  (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_out_req     (r_out_req),
    .i_out_data    (r_out_data),
    .o_out_busy    (w_out_busy),
    .i_in_req      (r_in_req),
    .o_in_data     (w_in_data),
    .o_in_valid    (w_in_valid),
    .o_axi_err     (w_axi_err),
    .o_axi_awaddr  (w_awaddr),
    .o_axi_awprot  (w_awprot),
    .o_axi_awvalid (w_awvalid),
    .i_axi_awready (w_awready),
    .o_axi_wdata   (w_wdata),
    .o_axi_wstrb   (w_wstrb),
    .o_axi_wvalid  (w_wvalid),
    .i_axi_wready  (w_wready),
    .i_axi_bresp   (r_bresp),
    .i_axi_bvalid  (r_bvalid),
    .o_axi_bready  (w_bready),
    .o_axi_araddr  (w_araddr),
    .o_axi_arprot  (w_arprot),
    .o_axi_arvalid (w_arvalid),
    .i_axi_arready (w_arready),
    .i_axi_rdata   (r_rdata),
    .i_axi_rresp   (r_rresp),
    .i_axi_rvalid  (r_rvalid),
    .o_axi_rready  (w_rready)
  );

  assign w_arready = 1'b1;
  assign w_awready = r_aw_en;
  assign w_wready  = r_aw_en;
  assign w_aw_hit  = w_awvalid & w_awready;
  assign w_w_hit   = w_wvalid & w_wready;

  // UART Lite slave: answers reads one cycle after AR, logs every transaction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_aw_addr_q <= '0;
      r_w_data_q  <= '0;
    end else begin
      if (w_arvalid && w_arready) begin
        r_rvalid <= 1'b1;
        if (w_araddr == c_BASE + 32'h8) begin
          r_rdata <= r_stat_val;
          r_rresp <= r_stat_resp;
          log_kind.push_back(c_K_S);
        end else begin
          r_rdata <= r_rx_val;
          r_rresp <= 2'b00;
          log_kind.push_back(c_K_R);
          rx_addr.push_back(w_araddr);
        end
      end else if (r_rvalid && w_rready) begin
        r_rvalid <= 1'b0;
      end
      if (w_aw_hit) r_aw_addr_q <= w_awaddr;
      if (w_w_hit)  r_w_data_q  <= w_wdata;
      if ((r_aw_got || w_aw_hit) && (r_w_got || w_w_hit)) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
        r_bvalid <= 1'b1;
        log_kind.push_back(c_K_W);
        wr_addr.push_back(w_aw_hit ? w_awaddr : r_aw_addr_q);
        wr_data.push_back(w_w_hit ? w_wdata : r_w_data_q);
      end else begin
        if (w_aw_hit) r_aw_got <= 1'b1;
        if (w_w_hit)  r_w_got  <= 1'b1;
      end
      if (r_bvalid && w_bready) r_bvalid <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    r_out_req  = 1'b1;
    r_out_data = {24'hABCDEF, b};
    @(negedge clk);
    r_out_req  = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n);
    for (int i = 0; i < 1000 && wr_data.size() < n; i++) @(negedge clk);
    check(tag, 32'(wr_data.size() >= n), 32'd1);
  endtask

  task automatic drain_rx(input string tag);
    r_in_req = 1'b1;
    for (int i = 0; i < 40 && w_in_valid; i++) @(negedge clk);
    r_in_req = 1'b0;
    check(tag, 32'(w_in_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; r_out_req = 1'b0; r_out_data = '0; r_in_req = 1'b0;
    r_stat_val = 32'h0; r_stat_resp = 2'b00; r_rx_val = 32'h0; r_aw_en = 1'b1;
    #1;
    check("rst_valids", {27'b0, w_arvalid, w_awvalid, w_wvalid, w_rready, w_bready}, 32'd0);
    check("rst_flags", {29'b0, w_out_busy, w_in_valid, w_axi_err}, 32'd0);
    check("tie_prot_strb", {22'b0, w_awprot, w_arprot, w_wstrb}, 32'h1);
    cycles(2);
    rst_n = 1'b1;
    cycles(10);

    // 1: two TX bytes with STAT=0
    lstart = log_kind.size();
    wstart = wr_data.size();
    push(8'h41);
    push(8'h42);
    check("t1_busy", 32'(w_out_busy), 32'd0);
    wait_writes("t1_wait", wstart + 2);
    check("t1_w0", wr_data[wstart], 32'h41);
    check("t1_w1", wr_data[wstart+1], 32'h42);
    check("t1_a0", wr_addr[wstart], c_BASE + 32'h4);
    check("t1_a1", wr_addr[wstart+1], c_BASE + 32'h4);
    pre_ok = 1'b1;
    for (int k = lstart; k < log_kind.size(); k++)
      if (log_kind[k] == c_K_W && (k == 0 || log_kind[k-1] != c_K_S)) pre_ok = 1'b0;
    check("t1_stat_before_w", 32'(pre_ok), 32'd1);

    // 2: one RX byte
    r_rx_val = 32'h0000_015A;
    r_stat_val = 32'h01;
    for (int i = 0; i < 200 && rx_addr.size() == 0; i++) @(negedge clk);
    r_stat_val = 32'h00;
    check("t2_rx_seen", 32'(rx_addr.size() == 1), 32'd1);
    cycles(8);
    check("t2_rx_addr", rx_addr[0], c_BASE);
    check("t2_in_valid", 32'(w_in_valid), 32'd1);
    check("t2_in_data", 32'(w_in_data), 32'h5A);
    r_in_req = 1'b1;
    @(negedge clk);
    r_in_req = 1'b0;
    check("t2_popped", 32'(w_in_valid), 32'd0);

    // 3: TX full in STAT blocks writes while RX still serviced
    r_rx_val = 32'h3C;
    r_stat_val = 32'h09;
    wstart = wr_data.size();
    nr = rx_addr.size();
    push(8'h33);
    cycles(40);
    check("t3_no_write", 32'(wr_data.size()), 32'(wstart));
    check("t3_rx_reads", 32'(rx_addr.size() > nr), 32'd1);
    check("t3_in_data", 32'(w_in_data), 32'h3C);
    r_stat_val = 32'h00;
    wait_writes("t3_wait", wstart + 1);
    check("t3_w", wr_data[wstart], 32'h33);
    cycles(5);
    drain_rx("t3_drain");

    // 4: RX and TX both ready -> strict alternation
    r_stat_val = 32'h08;
    r_rx_val = 32'h77;
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    cycles(10);
    wstart = wr_data.size();
    lstart = log_kind.size();
    r_stat_val = 32'h01;
    wait_writes("t4_wait", wstart + 4);
    r_stat_val = 32'h00;
    for (int k = 0; k < 4; k++) check("t4_wdata", wr_data[wstart+k], 32'hA1 + 32'(k));
    alt_ok = 1'b1; nw = 0; nr = 0; prev_kind = 8'h00;
    for (int k = lstart; k < log_kind.size() && nw < 4; k++) begin
      if (log_kind[k] != c_K_S) begin
        if (log_kind[k] == prev_kind) alt_ok = 1'b0;
        prev_kind = log_kind[k];
        if (log_kind[k] == c_K_W) nw++; else nr++;
      end
    end
    check("t4_alternate", 32'(alt_ok), 32'd1);
    check("t4_rx_between", 32'(nr >= 3), 32'd1);
    cycles(20);
    drain_rx("t4_drain");

    // 5: fill TX FIFO with the slave stalled
    r_aw_en = 1'b0;
    wstart = wr_data.size();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("t5_busy_15", 32'(w_out_busy), 32'd0);
      push(8'hB0 + 8'(i));
    end
    check("t5_busy_16", 32'(w_out_busy), 32'd1);
    push(8'hEE);
    cycles(10);
    check("t5_aw_stall", {31'b0, w_awvalid & w_wvalid}, 32'd1);
    check("t5_wdata_hold", w_wdata, 32'hB0);
    r_aw_en = 1'b1;
    r_out_req = 1'b1;
    r_out_data = 32'hEF;
    @(negedge clk);
    r_out_req = 1'b0;
    r_aw_en = 1'b0;
    check("t5_busy_pushpop", 32'(w_out_busy), 32'd1);
    cycles(10);
    r_aw_en = 1'b1;
    wait_writes("t5_wait", wstart + 17);
    for (int k = 0; k < 16; k++) check("t5_wdata", wr_data[wstart+k], 32'hB0 + 32'(k));
    check("t5_wdata_last", wr_data[wstart+16], 32'hEF);
    cycles(10);
    check("t5_no_extra", 32'(wr_data.size()), 32'(wstart + 17));

    // 6: error response is sticky; reset mid-write aborts everything
    check("t6_err_pre", 32'(w_axi_err), 32'd0);
    r_stat_resp = 2'b10;
    for (int i = 0; i < 50 && !w_axi_err; i++) @(negedge clk);
    r_stat_resp = 2'b00;
    check("t6_err_set", 32'(w_axi_err), 32'd1);
    cycles(20);
    check("t6_err_sticky", 32'(w_axi_err), 32'd1);
    r_rx_val = 32'h99;
    r_stat_val = 32'h01;
    for (int i = 0; i < 100 && !w_in_valid; i++) @(negedge clk);
    r_stat_val = 32'h00;
    cycles(10);
    r_aw_en = 1'b0;
    push(8'h55);
    push(8'h56);
    for (int i = 0; i < 100 && !w_awvalid; i++) @(negedge clk);
    check("t6_in_tx_aw", {30'b0, w_awvalid, w_in_valid}, 32'd3);
    wstart = wr_data.size();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valids", {27'b0, w_arvalid, w_awvalid, w_wvalid, w_rready, w_bready}, 32'd0);
    check("t6_rst_flags", {29'b0, w_out_busy, w_in_valid, w_axi_err}, 32'd0);
    cycles(2);
    rst_n = 1'b1;
    r_aw_en = 1'b1;
    cycles(40);
    check("t6_tx_flushed", 32'(wr_data.size()), 32'(wstart));
    check("t6_rx_flushed", 32'(w_in_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
